// File: rtl/rp_pio_pkg.sv
// Shared types and helpers for the root-port PIO completion monitor.
// Error bits follow the RP PIO SysError register layout.
package rp_pio_pkg;

    typedef enum logic [1:0] {
        PIO_CFG = 2'b00,
        PIO_IO  = 2'b01,
        PIO_MEM = 2'b10
    } pio_type_e;

    typedef enum logic [1:0] {
        ERR_UR  = 2'd0,
        ERR_CA  = 2'd1,
        ERR_CTO = 2'd2
    } pio_err_e;

    localparam logic [1:0] PIO_RSVD = 2'b11;

    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    localparam int unsigned BASE_CFG = 0;
    localparam int unsigned BASE_IO  = 8;
    localparam int unsigned BASE_MEM = 16;

    localparam int unsigned OFS_UR  = 0;
    localparam int unsigned OFS_CA  = 1;
    localparam int unsigned OFS_CTO = 2;

    // One-hot SysError bit for a request type / error kind pair.
    function automatic logic [31:0] err_bit(input pio_type_e t, input pio_err_e e);
        int unsigned base;
        int unsigned ofs;
        case (t)
            PIO_IO:  base = BASE_IO;
            PIO_MEM: base = BASE_MEM;
            default: base = BASE_CFG;
        endcase
        case (e)
            ERR_CA:  ofs = OFS_CA;
            ERR_CTO: ofs = OFS_CTO;
            default: ofs = OFS_UR;
        endcase
        return 32'(1) << (base + ofs);
    endfunction

endpackage

// File: rtl/rp_pio_tag_entry.sv
// One outstanding-request slot: valid flag, request type and age counter.
// Frees itself on its own timeout; the top frees it on a matching completion.
module rp_pio_tag_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TMR_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    input  logic [1:0] alloc_type,
    input  logic       cpl_hit,
    output logic       free,
    output logic [1:0] ptype,
    output logic       timeout_hit
);

    localparam logic [TMR_W-1:0] AGE_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic             valid;
    logic [TMR_W-1:0] age;

    // alloc only fires on a free slot and cpl_hit/timeout only on a valid one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ptype <= 2'b00;
            age   <= '0;
        end else if (alloc) begin
            valid <= 1'b1;
            ptype <= alloc_type;
            age   <= '0;
        end else if (cpl_hit || timeout_hit) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (valid) begin
            age <= age + TMR_W'(1);
        end
    end

    assign free        = ~valid;
    assign timeout_hit = valid & (age == AGE_LAST);

endmodule

// File: rtl/rp_pio_cpl_monitor.sv
// Tracks outstanding PIO requests per tag and turns UR/CA/CTO events into
// a single-cycle SysError set pulse.
module rp_pio_cpl_monitor
    import rp_pio_pkg::*;
#(
    parameter int unsigned NUM_TAGS       = 8,
    parameter int unsigned TAG_W          = $clog2(NUM_TAGS),
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TMR_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [1:0]       req_type,
    output logic             req_ready,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [2:0]       cpl_status,
    output logic             err_valid,
    output logic [31:0]      err_data,
    output logic             unexp_cpl,
    output logic [TAG_W:0]   outstanding
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [NUM_TAGS-1:0] free;
    logic [NUM_TAGS-1:0] timeout_hit;
    logic [NUM_TAGS-1:0] alloc;
    logic [NUM_TAGS-1:0] cpl_hit;
    logic [1:0]          ptype [NUM_TAGS];
    logic                req_accept;
    logic [31:0]         err_next;
    logic                unexp_next;
    logic [CNT_W-1:0]    cnt_next;

    assign req_ready  = free[req_tag];
    assign req_accept = req_valid & req_ready & (req_type != PIO_RSVD);

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
        assign alloc[g]   = req_accept & (req_tag == TAG_W'(g));
        assign cpl_hit[g] = cpl_valid & (cpl_tag == TAG_W'(g)) & ~free[g];

        rp_pio_tag_entry #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .TMR_W          (TMR_W)
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .alloc       (alloc[g]),
            .alloc_type  (req_type),
            .cpl_hit     (cpl_hit[g]),
            .free        (free[g]),
            .ptype       (ptype[g]),
            .timeout_hit (timeout_hit[g])
        );
    end

    // Merge the completion status error and every timeout into one word
    always_comb begin
        err_next   = '0;
        unexp_next = cpl_valid & free[cpl_tag];
        if (cpl_valid && !free[cpl_tag]) begin
            case (cpl_status)
                CPL_SC, CPL_CRS: ;
                CPL_CA:  err_next = err_next | err_bit(pio_type_e'(ptype[cpl_tag]), ERR_CA);
                default: err_next = err_next | err_bit(pio_type_e'(ptype[cpl_tag]), ERR_UR);
            endcase
        end
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (timeout_hit[i] && !cpl_hit[i]) begin
                err_next = err_next | err_bit(pio_type_e'(ptype[i]), ERR_CTO);
            end
        end
    end

    // Population count of entries that will be valid after this edge
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if ((~free[i] & ~cpl_hit[i] & ~timeout_hit[i]) | alloc[i]) begin
                cnt_next = cnt_next + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid   <= 1'b0;
            err_data    <= '0;
            unexp_cpl   <= 1'b0;
            outstanding <= '0;
        end else begin
            err_valid   <= |err_next;
            err_data    <= err_next;
            unexp_cpl   <= unexp_next;
            outstanding <= cnt_next;
        end
    end

endmodule

// File: tb/tb_rp_pio_cpl_monitor.sv
// Directed bench for rp_pio_cpl_monitor: a deadline-based tag model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_rp_pio_cpl_monitor;

    localparam int NT = 8;
    localparam int TW = 3;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic [1:0]    req_type = '0;
    logic          req_ready;
    logic          cpl_valid = 1'b0;
    logic [TW-1:0] cpl_tag = '0;
    logic [2:0]    cpl_status = '0;
    logic          err_valid;
    logic [31:0]   err_data;
    logic          unexp_cpl;
    logic [TW:0]   outstanding;

    rp_pio_cpl_monitor #(
        .NUM_TAGS       (NT),
        .TAG_W          (TW),
        .TIMEOUT_CYCLES (T),
        .TMR_W          (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_type    (req_type),
        .req_ready   (req_ready),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .cpl_status  (cpl_status),
        .err_valid   (err_valid),
        .err_data    (err_data),
        .unexp_cpl   (unexp_cpl),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each live tag remembers the edge it was accepted on; it times
    // out exactly T edges later unless a completion arrives first.
    bit          m_valid [NT];
    int          m_type  [NT];
    int          m_acc   [NT];
    int          cyc = 0;
    logic        x_ev = 1'b0;
    logic [31:0] x_ed = '0;
    logic        x_un = 1'b0;
    int          x_out = 0;

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
        x_ev = 1'b0; x_ed = '0; x_un = 1'b0; x_out = 0;
    endtask

    task automatic model_step();
        logic [31:0] e;
        logic        u;
        bit          acc;
        int          t;
        e = '0; u = 1'b0;
        cyc++;
        acc = req_valid && !m_valid[int'(req_tag)] && (req_type != 2'b11);
        if (cpl_valid) begin
            t = int'(cpl_tag);
            if (m_valid[t]) begin
                if (cpl_status == 3'b100)
                    e |= 32'(1) << (8 * m_type[t] + 1);
                else if (cpl_status != 3'b000 && cpl_status != 3'b010)
                    e |= 32'(1) << (8 * m_type[t]);
                m_valid[t] = 1'b0;
            end else begin
                u = 1'b1;
            end
        end
        for (int i = 0; i < NT; i++) begin
            if (m_valid[i] && cyc == m_acc[i] + T) begin
                e |= 32'(1) << (8 * m_type[i] + 2);
                m_valid[i] = 1'b0;
            end
        end
        if (acc) begin
            m_valid[int'(req_tag)] = 1'b1;
            m_type[int'(req_tag)]  = int'(req_type);
            m_acc[int'(req_tag)]   = cyc;
        end
        x_ev = (e != 0); x_ed = e; x_un = u;
        x_out = 0;
        for (int i = 0; i < NT; i++) if (m_valid[i]) x_out++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("err_valid", 32'(err_valid), 32'(x_ev));
            chk("err_data", err_data, x_ed);
            chk("unexp_cpl", 32'(unexp_cpl), 32'(x_un));
            chk("outstanding", 32'(outstanding), 32'(x_out));
            chk("req_ready", 32'(req_ready), 32'(!m_valid[int'(req_tag)]));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input int tag, input int typ);
        req_valid = 1'b1; req_tag = TW'(tag); req_type = 2'(typ);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_cpl(input int tag, input int st);
        cpl_valid = 1'b1; cpl_tag = TW'(tag); cpl_status = 3'(st);
        tick();
        cpl_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin
            m_valid[i] = 1'b0; m_type[i] = 0; m_acc[i] = 0;
        end
        tick(2);
        chk_en = 1'b1;
        chk("reset_err_valid", 32'(err_valid), 32'd0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // mem tag 3, UR completion five cycles later
        do_req(3, 2);
        chk("mem_out_1", 32'(outstanding), 32'd1);
        tick(4);
        do_cpl(3, 1);
        chk("mem_ur_valid", 32'(err_valid), 32'd1);
        chk("mem_ur_data", err_data, 32'h0001_0000);
        chk("mem_ur_out", 32'(outstanding), 32'd0);
        tick();
        chk("mem_ur_one_cycle", 32'(err_valid), 32'd0);

        // cfg tag 0 times out T edges after accept
        do_req(0, 0);
        tick(T - 1);
        chk("cto_not_early", 32'(err_valid), 32'd0);
        tick();
        chk("cto_valid", 32'(err_valid), 32'd1);
        chk("cto_data", err_data, 32'h0000_0004);
        chk("cto_freed", 32'(outstanding), 32'd0);
        tick(2);

        // io tag 1, CA completion in the last on-time cycle
        do_req(1, 1);
        tick(T - 1);
        do_cpl(1, 4);
        chk("ca_edge_data", err_data, 32'h0000_0200);
        tick(3);
        chk("ca_edge_no_cto", 32'(err_valid), 32'd0);

        // completion on free tag 5
        do_cpl(5, 0);
        chk("unexp_pulse", 32'(unexp_cpl), 32'd1);
        chk("unexp_no_err", 32'(err_valid), 32'd0);
        tick();
        chk("unexp_once", 32'(unexp_cpl), 32'd0);

        // cfg tag 0 CTO merged with io tag 1 CA completion in the same cycle
        do_req(0, 0);
        do_req(1, 1);
        tick(T - 2);
        do_cpl(1, 4);
        chk("merge_data", err_data, 32'h0000_0204);
        chk("merge_out", 32'(outstanding), 32'd0);
        tick(2);

        // occupied tag 2 rejects a second request; reserved type never allocates
        do_req(2, 2);
        req_valid = 1'b1; req_tag = 3'd2; req_type = 2'b00;
        #1;
        chk("busy_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("busy_out", 32'(outstanding), 32'd1);
        do_cpl(2, 7);
        chk("busy_type_kept", err_data, 32'h0001_0000);
        do_req(4, 3);
        chk("rsvd_no_alloc", 32'(outstanding), 32'd0);
        do_cpl(4, 0);
        chk("rsvd_unexp", 32'(unexp_cpl), 32'd1);

        // tag freed by a completion can be re-requested the next cycle
        do_req(6, 1);
        do_cpl(6, 2);
        chk("crs_no_err", 32'(err_valid), 32'd0);
        do_req(6, 2);
        chk("rereq_out", 32'(outstanding), 32'd1);
        do_cpl(6, 0);

        // reset with three entries outstanding
        do_req(5, 0);
        do_req(6, 1);
        do_req(7, 2);
        chk("pre_rst_out", 32'(outstanding), 32'd3);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", 32'(outstanding), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(T + 4);
        chk("post_rst_no_cto", 32'(err_valid), 32'd0);
        chk("post_rst_out", 32'(outstanding), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
